execute_ctrl: RTL

EXECUTE_CTRL -- requirements
Module: execute_ctrl

---
 rtl/execute_pkg.sv | 31 +++
 rtl/alu_ctrl_decode.sv | 33 +++
 rtl/execute_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// Shared types and constants for the execute-stage controller.
// Holds the FSM state enum, ALU function codes, ALUOp and funct encodings.
package execute_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
`ifdef EXECUTE_CTRL_MDU_EN
        MDU  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] FC_AND = 4'b0000;
    localparam logic [3:0] FC_OR  = 4'b0001;
    localparam logic [3:0] FC_ADD = 4'b0010;
    localparam logic [3:0] FC_SUB = 4'b0110;
    localparam logic [3:0] FC_SLT = 4'b0111;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_RT  = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: alu_op/funct -> 4-bit function code.
// Ports: alu_op, funct in; funct_c, illegal out (unknown R-type funct).
module alu_ctrl_decode
    import execute_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] funct_c,
    output logic       illegal
);

    always_comb begin
        funct_c = FC_ADD;
        illegal = 1'b0;
        unique case (alu_op)
            OP_ADD: funct_c = FC_ADD;
            OP_BR:  funct_c = FC_SUB;
            OP_OR:  funct_c = FC_OR;
            OP_RT: begin
                unique case (1'b1)
                    (funct == FN_ADD): funct_c = FC_ADD;
                    (funct == FN_SUB): funct_c = FC_SUB;
                    (funct == FN_AND): funct_c = FC_AND;
                    (funct == FN_OR):  funct_c = FC_OR;
                    (funct == FN_SLT): funct_c = FC_SLT;
                    default:           illegal = 1'b1;
                endcase
            end
            default: funct_c = FC_ADD;
        endcase
    end

endmodule

// File: rtl/execute_ctrl.sv
// Execute-stage controller: handshake FSM, ALU control, branch, MDU timing.
// Ports: clk, rst (sync, high); id_valid/id_ready from decode;
// alu_op, funct, alu_src_in, is_branch, br_ne, is_muldiv, alu_zero in;
// funct_c, alu_src, mdu_start, ex_valid, branch_taken, flush, illegal_op
// out; ex_ready from memory stage.
// Build option EXECUTE_CTRL_MDU_EN enables the multiply/divide path.
module execute_ctrl
    import execute_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic       alu_src_in,
    input  logic       is_branch,
    input  logic       br_ne,
    input  logic       is_muldiv,
    input  logic       alu_zero,
    output logic [3:0] funct_c,
    output logic       alu_src,
    output logic       mdu_start,
    output logic       ex_valid,
    input  logic       ex_ready,
    output logic       branch_taken,
    output logic       flush,
    output logic       illegal_op
);

    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic [3:0] dec_fc;
    logic       dec_ill;
    logic [3:0] sel_fc;
    logic       sel_ill;
    logic       is_br_q;
    logic       br_ne_q;

    alu_ctrl_decode u_dec (
        .alu_op  (alu_op),
        .funct   (funct),
        .funct_c (dec_fc),
        .illegal (dec_ill)
    );

`ifdef EXECUTE_CTRL_MDU_EN
    localparam int CW = $clog2(MDU_LAT);
    logic [CW-1:0] cnt_q;

    assign sel_fc  = dec_fc;
    assign sel_ill = dec_ill;
`else
    logic [6:0] lat_unused;
    assign lat_unused = 7'(MDU_LAT);

    // Without a multiply/divide unit such ops fall through as illegal adds.
    assign sel_fc    = is_muldiv ? FC_ADD : dec_fc;
    assign sel_ill   = is_muldiv | dec_ill;
    assign mdu_start = 1'b0;
`endif

    assign accept = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        id_ready = 1'b0;
        ex_valid = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: id_ready = !rst;
            EXEC: state_d = DONE;
`ifdef EXECUTE_CTRL_MDU_EN
            MDU: begin
                if (cnt_q == '0) state_d = DONE;
            end
`endif
            DONE: begin
                ex_valid = !rst;
                if (ex_ready) begin
                    id_ready = !rst;
                    flush    = branch_taken & !rst;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
`ifdef EXECUTE_CTRL_MDU_EN
            state_d = is_muldiv ? MDU : EXEC;
`else
            state_d = EXEC;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct_c      <= FC_ADD;
            alu_src      <= 1'b0;
            is_br_q      <= 1'b0;
            br_ne_q      <= 1'b0;
            illegal_op   <= 1'b0;
            branch_taken <= 1'b0;
`ifdef EXECUTE_CTRL_MDU_EN
            mdu_start    <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
`ifdef EXECUTE_CTRL_MDU_EN
            mdu_start <= 1'b0;
`endif
            if (accept) begin
                funct_c      <= sel_fc;
                alu_src      <= alu_src_in;
                is_br_q      <= is_branch;
                br_ne_q      <= br_ne;
                illegal_op   <= sel_ill;
                branch_taken <= 1'b0;
`ifdef EXECUTE_CTRL_MDU_EN
                if (is_muldiv) begin
                    mdu_start <= 1'b1;
                    cnt_q     <= CW'(MDU_LAT - 1);
                end
`endif
            end else if (state_q == EXEC) begin
                // Zero flag is valid during the single EXEC cycle.
                branch_taken <= is_br_q & (alu_zero ^ br_ne_q);
            end
`ifdef EXECUTE_CTRL_MDU_EN
            else if (state_q == MDU && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
`endif
        end
    end

endmodule
